// File: rtl/fmul_result_buffer.sv
// fmul_result_buffer: show-ahead FIFO behind a fixed-latency multiplier, with in-flight tracking
// and issue credit so that no product is ever dropped under legal use.
module fmul_result_buffer #(
    parameter int DEPTH   = 16,
    parameter int MUL_LAT = 14,
    parameter int WIDTH   = 64,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue,
    output logic             credit_ok,
    input  logic [WIDTH-1:0] mul_result,
    input  logic             mul_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    inflight,
    output logic [2:0]       err
);
    localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    if (DEPTH < MUL_LAT + 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least MUL_LAT+2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW:0]      used;
    logic             full, pop, push_ok;

    assign out_valid = count != '0;
    assign full      = count == FULL;
    assign pop       = out_valid & out_ready;
    // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
    assign push_ok   = mul_ready & (!full | pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign used      = {1'b0, inflight} + {1'b0, count};
    assign credit_ok = used < LIMIT;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= mul_result;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            err      <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            if (issue && !mul_ready && inflight != '1) inflight <= inflight + 1'b1;
            else if (mul_ready && !issue && inflight != '0) inflight <= inflight - 1'b1;
            err <= err | {mul_ready & full & !pop, mul_ready & (inflight == '0), issue & !credit_ok};
        end
    end
endmodule

// File: tb/tb_fmul_result_buffer.sv
// tb_fmul_result_buffer: directed checks of the result buffer against a 14-cycle multiplier model.
module tb_fmul_result_buffer;
    localparam int LAT = 14;

    logic        clk = 0, rstn = 0, issue = 0, out_ready = 0;
    logic        force_rdy = 0;
    logic [63:0] force_data = '0, issue_data = '0;
    logic        credit_ok, mul_ready, out_valid;
    logic [63:0] mul_result, out_data;
    logic [4:0]  count, inflight;
    logic [2:0]  err;
    logic [LAT-1:0]       pv;
    logic [LAT-1:0][63:0] pd;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    // Multiplier model: fixed latency delay line, optionally overridden by a forced return.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            pd <= '0;
        end else begin
            pv <= {pv[LAT-2:0], issue};
            pd <= {pd[LAT-2:0], issue_data};
        end
    end
    assign mul_ready  = force_rdy | pv[LAT-1];
    assign mul_result = force_rdy ? force_data : pd[LAT-1];

    fmul_result_buffer dut (
        .clk(clk), .rstn(rstn), .issue(issue), .credit_ok(credit_ok),
        .mul_result(mul_result), .mul_ready(mul_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .inflight(inflight), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 0; issue = 0; force_rdy = 0; out_ready = 0;
        repeat (2) tick();
        rstn = 1;
        tick();
    endtask

    task automatic push_val(input logic [63:0] v, input logic rdy);
        force_rdy = 1; force_data = v; out_ready = rdy;
        tick();
        force_rdy = 0; out_ready = 0;
    endtask

    task automatic fill(input logic [63:0] base, output int n);
        n = 0; out_ready = 0;
        for (int c = 0; c < 40; c++) begin
            issue = credit_ok;
            if (credit_ok) n++;
            issue_data = base + 64'(n);
            tick();
            if (issue && n == 16) chk("credit_after_16", credit_ok, 0);
        end
        issue = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, idx, got_n, first_c, last_c;
        bit order_ok, credit_all, cnt_ok, inf_ok;
        logic [63:0] exp5 [17];

        // T1 reset values, held in reset
        #2;
        chk("rst_count", count, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_credit", credit_ok, 1);
        repeat (2) tick();
        rstn = 1;
        tick();

        // T2 single product
        issue = 1; issue_data = 64'h4000000000000000;
        tick();
        issue = 0;
        for (int i = 1; i <= 14; i++) begin
            chk("t2_inflight", inflight, 1);
            if (i == 14) chk("t2_no_bypass", out_valid, 0);
            tick();
        end
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 64'h4000000000000000);
        chk("t2_inflight_done", inflight, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("t2_count_after_pop", count, 0);

        // T3 backpressure fill and ordered drain
        fill(0, n);
        chk("t3_issues", n, 16);
        chk("t3_count", count, 16);
        chk("t3_inflight", inflight, 0);
        chk("t3_err", err, 0);
        chk("t3_credit", credit_ok, 0);
        out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            chk("t3_drain", out_data, 64'(i));
            tick();
        end
        out_ready = 0;
        chk("t3_empty", out_valid, 0);

        // T4 full with simultaneous push and pop (forced return, so err[1] is expected)
        fill(64'h200, n);
        chk("t4_full", count, 16);
        chk("t4_head", out_data, 64'h201);
        push_val(64'hAA, 1);
        chk("t4_count", count, 16);
        chk("t4_head_adv", out_data, 64'h202);
        chk("t4_no_drop", err[2], 0);
        chk("t4_unexp", err[1], 1);
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain", out_data, i < 15 ? 64'h202 + 64'(i) : 64'hAA);
            tick();
        end
        out_ready = 0;

        // T1 asynchronous reset in the middle of a fill
        do_reset();
        for (int c = 0; c < 20; c++) begin
            issue = credit_ok; issue_data = 64'(c + 1);
            tick();
        end
        issue = 0;
        #2 rstn = 0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_inflight", inflight, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_credit", credit_ok, 1);
        repeat (2) tick();
        rstn = 1;
        tick();

        // T5 error flags
        push_val(64'h11, 0);
        chk("t5_unexp_err", err, 3'b010);
        chk("t5_count1", count, 1);
        for (int i = 1; i <= 15; i++) push_val(64'h100 + 64'(i), 0);
        chk("t5_full", count, 16);
        chk("t5_no_credit", credit_ok, 0);
        issue = 1; issue_data = 64'h77;
        tick();
        issue = 0;
        chk("t5_issue_err", err, 3'b011);
        chk("t5_inflight", inflight, 1);
        push_val(64'hDEAD, 0);
        chk("t5_drop_err", err, 3'b111);
        chk("t5_drop_count", count, 16);
        chk("t5_drop_head", out_data, 64'h11);
        exp5[0] = 64'h11;
        for (int i = 1; i <= 15; i++) exp5[i] = 64'h100 + 64'(i);
        exp5[16] = 64'h77;
        idx = 0;
        out_ready = 1;
        for (int c = 0; c < 40 && idx < 17; c++) begin
            if (out_valid) begin
                chk("t5_order", out_data, exp5[idx]);
                idx++;
            end
            tick();
        end
        out_ready = 0;
        chk("t5_drained", idx, 17);
        chk("t5_err_sticky", err, 3'b111);

        // T6 streaming throughput
        do_reset();
        got_n = 0; first_c = -1; last_c = -1;
        order_ok = 1; credit_all = 1; cnt_ok = 1; inf_ok = 1;
        out_ready = 1;
        for (int c = 0; c < 140; c++) begin
            if (out_valid) begin
                if (out_data !== 64'(1000 + got_n)) order_ok = 0;
                if (first_c < 0) first_c = c;
                last_c = c;
                got_n++;
            end
            if (count > 1) cnt_ok = 0;
            if (c >= 14 && c <= 100 && inflight != 14) inf_ok = 0;
            if (c < 100) begin
                if (!credit_ok) credit_all = 0;
                issue = 1; issue_data = 64'(1000 + c);
            end else issue = 0;
            tick();
        end
        out_ready = 0;
        chk("t6_credit", credit_all, 1);
        chk("t6_count_le1", cnt_ok, 1);
        chk("t6_inflight14", inf_ok, 1);
        chk("t6_order", order_ok, 1);
        chk("t6_products", got_n, 100);
        chk("t6_first", first_c, 15);
        chk("t6_no_gaps", last_c - first_c, 99);
        chk("t6_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
